item_select_queue: RTL and testbench
====================================

// Module: item_select_queue
// PURPOSE
//  Parametrised selection front-end for the vending datapath. Range-checks keypad item
//  selections and buffers up to DEPTH accepted selections in FIFO order. Presents them
//  to the dispense controller over a valid/ready handshake. Adds queueing, back-pressure,
//  cancel/flush and error reporting for out-of-range or overflowing requests.
// PARAMETERS
//  ITEM_ADDR_WIDTH  10    width of an item address
//  NUM_ITEMS        1000  valid item codes are 0..NUM_ITEMS-1 (NUM_ITEMS <= 2**ITEM_ADDR_WIDTH)
//  DEPTH            4     queue entries (>= 2, need not be a power of 2)
//  CW               derived $clog2(DEPTH+1), width of pending_count (localparam)
// PORTS
//  clk                input   1                system clock, rising edge
//  rstn               input   1                asynchronous active-low reset
//  item_select        input   ITEM_ADDR_WIDTH  requested item code
//  item_select_valid  input   1                request strobe, one request per cycle
//  item_select_ready  output  1                queue can accept (combinational: count < DEPTH)
//  cancel             input   1                synchronous flush of all pending selections
//  item_selected      output  ITEM_ADDR_WIDTH  head-of-queue item code
//  selection_valid    output  1                head entry is valid
//  selection_ready    input   1                dispense controller consumes head this cycle
//  pending_count      output  CW               number of queued entries, 0..DEPTH
//  err_range          output  1                1-cycle pulse: out-of-range request dropped
//  err_overflow       output  1                1-cycle pulse: request dropped, queue full
// BEHAVIOUR
//  - Reset (rstn=0, async): rd/wr pointers=0, count=0, item_selected=0, selection_valid=0,
//    pending_count=0, err_range=0, err_overflow=0. item_select_ready=1 (count=0).
//  - Storage: circular buffer of DEPTH entries. wr_ptr/rd_ptr wrap from DEPTH-1 to 0
//    by explicit compare, not modulo-2**n.
//  - Push: item_select_valid && item_select < NUM_ITEMS && count < DEPTH && !cancel.
//    Entry written at wr_ptr, and wr_ptr advances.
//  - Range error: valid && item_select >= NUM_ITEMS && !cancel.
//    Request dropped; err_range=1 on next cycle only. Range check has priority over full.
//  - Overflow: valid && in-range && count == DEPTH && !cancel.
//    Request dropped; err_overflow=1 on next cycle only.
//  - Pop: selection_valid && selection_ready && !cancel, and rd_ptr advances.
//    selection_ready while !selection_valid is ignored.
//  - Output: registered first-word-fall-through.
//    selection_valid = (count != 0) and item_selected = mem[rd_ptr], both registered.
//    A push into an empty queue is visible one cycle after acceptance.
//    item_selected holds its last value when the queue is empty.
//  - Simultaneous push+pop: count unchanged and both pointers advance.
//    When full, ready is evaluated on the pre-pop count, so the push is rejected (err_overflow).
//  - Cancel: highest priority. Next cycle count=0, both pointers=0, selection_valid=0.
//    Same-cycle push/pop/errors suppressed; item_select_ready=1 the following cycle.
//  - pending_count = count, registered. Width rule: count never exceeds DEPTH.
//  - Reset mid-operation discards all entries immediately; no pulse outputs survive reset.
// TESTING
//  1 Reset, push codes 5,7,9 on consecutive cycles, selection_ready=0:
//    -> pending_count 1,2,3; selection_valid=1 with item_selected=5 one cycle after first push.
//  2 With the queue from test 1, hold selection_ready=1:
//    -> outputs 5,7,9 on successive cycles, then selection_valid=0, pending_count=0.
//  3 Push code 1000 (NUM_ITEMS=1000):
//    -> err_range pulse for exactly 1 cycle, pending_count unchanged.
//    -> code 999 is accepted normally.
//  4 Fill to DEPTH=4, push a 5th entry with selection_ready=1 in the same cycle:
//    -> 5th dropped, err_overflow pulses once, head popped, pending_count=3.
//  5 Push 6 items with interleaved pops to wrap pointers twice:
//    -> output order identical to input order.
//  6 With 3 entries queued, assert cancel together with a valid push:
//    -> next cycle pending_count=0, selection_valid=0, no error pulse, item_select_ready=1.
//    -> assert rstn=0 mid-queue: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/item_select_queue.sv
// item_select_queue: range-checked keypad selection FIFO with registered
// first-word-fall-through output, cancel/flush and error pulses.
module item_select_queue #(
    parameter int ITEM_ADDR_WIDTH = 10,
    parameter int NUM_ITEMS       = 1000,
    parameter int DEPTH           = 4,
    localparam int CW             = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ITEM_ADDR_WIDTH-1:0] item_select,
    input  logic                       item_select_valid,
    output logic                       item_select_ready,
    input  logic                       cancel,
    output logic [ITEM_ADDR_WIDTH-1:0] item_selected,
    output logic                       selection_valid,
    input  logic                       selection_ready,
    output logic [CW-1:0]              pending_count,
    output logic                       err_range,
    output logic                       err_overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so NUM_ITEMS == 2**ITEM_ADDR_WIDTH is representable.
    localparam logic [ITEM_ADDR_WIDTH:0] LIMIT     = (ITEM_ADDR_WIDTH+1)'(NUM_ITEMS);
    localparam logic [PW-1:0]            LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0]            DEPTH_CNT = CW'(DEPTH);

    logic [ITEM_ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [ITEM_ADDR_WIDTH-1:0] item_q, item_d;
    logic                       valid_q;
    logic                       err_range_q, err_range_d;
    logic                       err_ovf_q, err_ovf_d;
    logic                       in_range, push, pop;

    // Accept decisions and next-state for pointers, count and the head register.
    always_comb begin
        in_range    = {1'b0, item_select} < LIMIT;
        push        = item_select_valid && in_range && (count_q < DEPTH_CNT) && !cancel;
        pop         = valid_q && selection_ready && !cancel;
        err_range_d = item_select_valid && !in_range && !cancel;
        err_ovf_d   = item_select_valid && in_range && (count_q == DEPTH_CNT) && !cancel;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        if (cancel) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // Next head: the incoming word bypasses storage when it lands at the new head.
        item_d = item_q;
        if (count_d != '0)
            item_d = (push && (wr_ptr_q == rd_ptr_d)) ? item_select : mem_q[rd_ptr_d];
    end

    // Entry storage; contents are only read while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= item_select;
    end

    // Control state, registered outputs and single-cycle error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            item_q      <= '0;
            valid_q     <= 1'b0;
            err_range_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            item_q      <= item_d;
            valid_q     <= (count_d != '0);
            err_range_q <= err_range_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign item_select_ready = count_q < DEPTH_CNT;
    assign item_selected     = item_q;
    assign selection_valid   = valid_q;
    assign pending_count     = count_q;
    assign err_range         = err_range_q;
    assign err_overflow      = err_ovf_q;

endmodule

// File: tb/tb_item_select_queue.sv
// Randomised + directed bench for item_select_queue against a queue-based model.
module tb_item_select_queue;

    localparam int W     = 10;
    localparam int NI    = 1000;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [W-1:0]  item_select = '0;
    logic          item_select_valid = 1'b0;
    logic          item_select_ready;
    logic          cancel = 1'b0;
    logic [W-1:0]  item_selected;
    logic          selection_valid;
    logic          selection_ready = 1'b0;
    logic [CW-1:0] pending_count;
    logic          err_range;
    logic          err_overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int q[$];
    int m_last = 0;
    bit m_er = 0, m_eo = 0;

    item_select_queue #(.ITEM_ADDR_WIDTH(W), .NUM_ITEMS(NI), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .item_select(item_select), .item_select_valid(item_select_valid),
        .item_select_ready(item_select_ready), .cancel(cancel),
        .item_selected(item_selected), .selection_valid(selection_valid),
        .selection_ready(selection_ready), .pending_count(pending_count),
        .err_range(err_range), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 0;
        m_er = 0;
        m_eo = 0;
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_edge(input bit v, input int code, input bit srdy, input bit cn);
        bit inr;
        bit do_pop, do_push;
        inr = code < NI;
        if (cn) begin
            q.delete();
            m_er = 0;
            m_eo = 0;
        end else begin
            m_er    = v && !inr;
            m_eo    = v && inr && (q.size() == DEPTH);
            do_pop  = (q.size() > 0) && srdy;
            do_push = v && inr && (q.size() < DEPTH);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(code);
        end
        if (q.size() > 0) m_last = q[0];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, int'(pending_count), q.size());
        chk({tag, ".valid"}, int'(selection_valid), int'(q.size() != 0));
        chk({tag, ".item"},  int'(item_selected), m_last);
        chk({tag, ".ready"}, int'(item_select_ready), int'(q.size() < DEPTH));
        chk({tag, ".erng"},  int'(err_range), int'(m_er));
        chk({tag, ".eovf"},  int'(err_overflow), int'(m_eo));
    endtask

    // Drive one cycle of inputs, clock it, then check outputs just after the edge.
    task automatic step(input string tag, input bit v, input int code,
                        input bit srdy, input bit cn);
        @(negedge clk);
        item_select_valid = v;
        item_select       = W'(code);
        selection_ready   = srdy;
        cancel            = cn;
        @(posedge clk);
        model_edge(v, code, srdy, cn);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input bit srdy);
        step(tag, 1'b0, 0, srdy, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rstn = 1'b1;

        // 1: three pushes, no consumption
        step("t1a", 1, 5, 0, 0);
        chk("t1.head5", int'(item_selected), 5);
        step("t1b", 1, 7, 0, 0);
        step("t1c", 1, 9, 0, 0);
        chk("t1.cnt3", int'(pending_count), 3);

        // 2: drain
        idle("t2a", 1);
        chk("t2.head7", int'(item_selected), 7);
        idle("t2b", 1);
        idle("t2c", 1);
        chk("t2.empty", int'(selection_valid), 0);
        idle("t2d", 1);

        // 3: out-of-range then boundary code
        step("t3a", 1, 1000, 0, 0);
        chk("t3.erng", int'(err_range), 1);
        idle("t3b", 0);
        step("t3c", 1, 999, 0, 0);
        chk("t3.head999", int'(item_selected), 999);

        // 4: fill, then 5th push alongside a pop
        step("t4a", 1, 11, 0, 0);
        step("t4b", 1, 12, 0, 0);
        step("t4c", 1, 13, 0, 0);
        chk("t4.full", int'(item_select_ready), 0);
        step("t4d", 1, 14, 1, 0);
        chk("t4.eovf", int'(err_overflow), 1);
        chk("t4.cnt3", int'(pending_count), 3);
        idle("t4e", 0);
        for (int i = 0; i < 3; i++) idle("t4f", 1);

        // 5: interleaved push/pop to wrap pointers
        for (int i = 0; i < 6; i++) begin
            step("t5p", 1, 100 + i, 0, 0);
            step("t5q", 1, 200 + i, 1, 0);
            idle("t5r", 1);
        end
        for (int i = 0; i < 4; i++) idle("t5d", 1);

        // 6: cancel with a simultaneous push, then async reset mid-queue
        step("t6a", 1, 21, 0, 0);
        step("t6b", 1, 22, 0, 0);
        step("t6c", 1, 23, 0, 0);
        step("t6d", 1, 24, 1, 1);
        chk("t6.cnt0", int'(pending_count), 0);
        chk("t6.rdy", int'(item_select_ready), 1);
        step("t6e", 1, 31, 0, 0);
        step("t6f", 1, 32, 0, 0);
        step("t6g", 1, 2000 % 1024, 0, 0);
        @(negedge clk);
        item_select_valid = 1'b0;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rstn = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit v, s, c;
            int code;
            v    = ($urandom_range(0, 3) != 0);
            s    = ($urandom_range(0, 2) != 0);
            c    = ($urandom_range(0, 29) == 0);
            code = ($urandom_range(0, 7) == 0) ? $urandom_range(NI, 1023)
                                               : $urandom_range(0, NI - 1);
            step("rnd", v, code, s, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
